// File: rtl/uart_apb_initiator_if.sv
// rtl/uart_apb_initiator_if.sv - APB bus and byte-stream bundle for uart_apb_initiator
//
// Groups the APB initiator pins, the tx/rx byte streams and the error/status
// sideband into one bundle.
//   master : initiator view (drives PSEL/PENABLE/PWRITE/PADDR/PWDATA,
//            tx_ready, rx_data/rx_valid, err_flags, init_done)
//   slave  : peripheral + console view (drives PRDATA/PREADY/PSLVERR,
//            tx_data/tx_valid, rx_ready, err_clr)
interface uart_apb_initiator_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [3:0] err_flags;
  logic       err_clr;
  logic       init_done;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready,
    output err_flags, init_done,
    input  err_clr
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready,
    input  err_flags, init_done,
    output err_clr
  );
endinterface

// File: rtl/uart_apb_initiator.sv
// rtl/uart_apb_initiator.sv - APB initiator that configures and services the UART peripheral
//
// Ports:
//   PCLK     : clock, rising edge
//   PRESETN  : asynchronous active-low reset
//   bus      : uart_apb_initiator_if.master - APB initiator pins, tx/rx byte
//              streams, sticky err_flags {pslverr, framing, overflow, parity},
//              err_clr and init_done
//
// Sequencer: CFG1 -> CFG2 -> POLL -> {RXR, TXW, POLL}; RXR/TXW return to POLL.
// Each state issues one APB transfer (SETUP, then ACCESS until PREADY).
module uart_apb_initiator #(
  parameter logic [7:0] BAUD_VALUE  = 8'd1,
  parameter logic [7:0] CTRL2_VALUE = 8'h01
) (
  input logic                  PCLK,
  input logic                  PRESETN,
  uart_apb_initiator_if.master bus
);

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  typedef enum logic [2:0] {ST_CFG1, ST_CFG2, ST_POLL, ST_TXW, ST_RXR} state_t;
  // PH_IDLE exists only for the single cycle after reset, so the bus is quiet
  // while PRESETN is low and the first SETUP lands in the first cycle after.
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

  state_t     r_state, w_state_nxt;
  phase_t     r_phase, w_phase_nxt;
  logic [7:0] r_tx_data;
  logic       r_tx_full;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic [3:0] r_err_flags;
  logic       r_init_done;

  logic       w_active;
  logic       w_done;
  logic       w_tx_accept;
  logic       w_rx_take;
  logic [3:0] w_err_set;

  assign w_active    = (r_phase != PH_IDLE);
  assign w_done      = (r_phase == PH_ACCESS) && bus.PREADY;
  assign w_tx_accept = bus.tx_valid && !r_tx_full;
  assign w_rx_take   = r_rx_valid && bus.rx_ready;

  // STATUS error bits only count when the sampled read really was STATUS.
  assign w_err_set = {w_done && bus.PSLVERR,
                      (w_done && (r_state == ST_POLL)) ? bus.PRDATA[4:2] : 3'b000};

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state <= ST_CFG1;
      r_phase <= PH_IDLE;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_IDLE:  w_phase_nxt = PH_SETUP;
      PH_SETUP: w_phase_nxt = PH_ACCESS;
      PH_ACCESS: begin
        if (bus.PREADY) begin
          w_phase_nxt = PH_SETUP;
          case (r_state)
            ST_CFG1: w_state_nxt = ST_CFG2;
            ST_CFG2: w_state_nxt = ST_POLL;
            ST_POLL: begin
              // RX first: an unread byte in the UART can be overwritten.
              if (bus.PRDATA[1] && !r_rx_valid)
                w_state_nxt = ST_RXR;
              else if (bus.PRDATA[0] && r_tx_full)
                w_state_nxt = ST_TXW;
              else
                w_state_nxt = ST_POLL;
            end
            default: w_state_nxt = ST_POLL;
          endcase
        end
      end
      default: w_phase_nxt = PH_IDLE;
    endcase
  end

  // Address/direction/data derive from the state register only, so they hold
  // steady for the whole SETUP..ACCESS span of a transfer.
  always_comb begin
    bus.PSEL    = w_active;
    bus.PENABLE = (r_phase == PH_ACCESS);
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 5'h00;
    bus.PWDATA  = 8'h00;
    if (w_active) begin
      case (r_state)
        ST_CFG1: begin bus.PWRITE = 1'b1; bus.PADDR = ADDR_CTRL1; bus.PWDATA = BAUD_VALUE;  end
        ST_CFG2: begin bus.PWRITE = 1'b1; bus.PADDR = ADDR_CTRL2; bus.PWDATA = CTRL2_VALUE; end
        ST_TXW:  begin bus.PWRITE = 1'b1; bus.PADDR = ADDR_TXDATA; bus.PWDATA = r_tx_data;  end
        ST_RXR:  bus.PADDR = ADDR_RXDATA;
        default: bus.PADDR = ADDR_STATUS;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_tx_data   <= 8'h00;
      r_tx_full   <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_err_flags <= 4'h0;
      r_init_done <= 1'b0;
    end else begin
      // tx_ready is low while full, so accept and TXW drain never coincide.
      if (w_tx_accept) begin
        r_tx_data <= bus.tx_data;
        r_tx_full <= 1'b1;
      end else if (w_done && (r_state == ST_TXW)) begin
        r_tx_full <= 1'b0;
      end

      // RXR is only entered with rx_valid low, so load and take are exclusive.
      if (w_done && (r_state == ST_RXR)) begin
        r_rx_data  <= bus.PRDATA;
        r_rx_valid <= 1'b1;
      end else if (w_rx_take) begin
        r_rx_valid <= 1'b0;
      end

      // A new error on the clearing edge survives the clear.
      r_err_flags <= (bus.err_clr ? 4'h0 : r_err_flags) | w_err_set;

      if (w_done && (r_state == ST_CFG2))
        r_init_done <= 1'b1;
    end
  end

  assign bus.tx_ready  = !r_tx_full;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.err_flags = r_err_flags;
  assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_uart_apb_initiator.sv
// tb/tb_uart_apb_initiator.sv - self-checking bench for uart_apb_initiator
module tb_uart_apb_initiator;

  localparam logic [7:0] TB_BAUD  = 8'h1B;
  localparam logic [7:0] TB_CTRL2 = 8'h01;

  logic PCLK = 1'b0;
  logic PRESETN = 1'b0;
  always #5 PCLK = ~PCLK;

  uart_apb_initiator_if bus();

  uart_apb_initiator #(.BAUD_VALUE(TB_BAUD), .CTRL2_VALUE(TB_CTRL2)) dut (
    .PCLK(PCLK),
    .PRESETN(PRESETN),
    .bus(bus.master)
  );

  typedef struct packed {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] data;
  } xfer_t;

  typedef struct packed {
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [4:0] paddr;
    logic [7:0] pwdata;
    logic       init_done;
    logic       tx_ready;
  } vec_t;

  xfer_t exp_q[$];
  xfer_t xf_got;
  xfer_t xf_exp;
  vec_t  vecs[8];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int poll_cnt = 0;
  int last_poll_cyc = 0;
  int poll_rx_cyc = -100;
  int tx_poll_idx = -1;
  int tx_delta = -1;
  int tx_writes = 0;
  int stall_left = 0;
  int lat;
  logic found;
  logic [7:0] status_val = 8'h00;
  logic [7:0] rxdata_val = 8'h00;
  logic slverr_tx = 1'b0;

  logic       prev_psel = 1'b0;
  logic       prev_pen = 1'b0;
  logic       prev_rdy = 1'b1;
  logic       prev_wr = 1'b0;
  logic [4:0] prev_addr = 5'h00;
  logic [7:0] prev_wd = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge PCLK);
    #1;
  endtask

  // Peripheral model, protocol watcher and scoreboard, all evaluated mid-cycle.
  always @(negedge PCLK) begin
    cyc++;
    if (!PRESETN) begin
      prev_psel = 1'b0;
      prev_pen = 1'b0;
      prev_rdy = 1'b1;
      bus.PREADY = 1'b1;
      bus.PSLVERR = 1'b0;
      bus.PRDATA = 8'h00;
    end else begin
      if (prev_psel && (!prev_pen || !prev_rdy)) begin
        if (!(bus.PSEL && bus.PENABLE) || bus.PADDR !== prev_addr ||
            bus.PWRITE !== prev_wr || bus.PWDATA !== prev_wd) begin
          n_err++;
          $display("FAIL apb_hold: got sel=%0b en=%0b wr=%0b addr=0x%0h wd=0x%0h, required sel=1 en=1 wr=%0b addr=0x%0h wd=0x%0h",
                   bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, prev_wr, prev_addr, prev_wd);
        end
      end

      bus.PREADY = 1'b1;
      if (bus.PSEL && bus.PENABLE && bus.PWRITE && bus.PADDR == 5'h00 && stall_left > 0) begin
        bus.PREADY = 1'b0;
        stall_left--;
      end
      bus.PSLVERR = bus.PSEL && bus.PENABLE && bus.PWRITE && (bus.PADDR == 5'h00) && slverr_tx;
      bus.PRDATA = (bus.PADDR == 5'h10) ? status_val :
                   (bus.PADDR == 5'h04) ? rxdata_val : 8'h00;

      if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
        if (bus.PADDR == 5'h10 && !bus.PWRITE) begin
          poll_cnt++;
          last_poll_cyc = cyc;
          if (bus.PRDATA[1]) poll_rx_cyc = cyc;
        end else begin
          xf_got = '{bus.PWRITE, bus.PADDR, (bus.PWRITE ? bus.PWDATA : bus.PRDATA)};
          if (bus.PWRITE && bus.PADDR == 5'h00) begin
            tx_writes++;
            tx_poll_idx = poll_cnt;
            tx_delta = cyc - last_poll_cyc;
          end
          if (!bus.PWRITE && bus.PADDR == 5'h04) status_val[1] = 1'b0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL xfer_unexpected: got wr=%0b addr=0x%0h data=0x%0h, required no transfer",
                     xf_got.wr, xf_got.addr, xf_got.data);
          end else begin
            xf_exp = exp_q.pop_front();
            chk("xfer", 32'(xf_got), 32'(xf_exp));
          end
        end
      end

      prev_psel = bus.PSEL;
      prev_pen = bus.PENABLE;
      prev_rdy = bus.PREADY;
      prev_wr = bus.PWRITE;
      prev_addr = bus.PADDR;
      prev_wd = bus.PWDATA;
    end
  end

  task automatic do_reset();
    PRESETN = 1'b0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    bus.err_clr = 1'b0;
    exp_q.delete();
    stall_left = 0;
    slverr_tx = 1'b0;
    repeat (2) tick();
    poll_cnt = 0;
    tx_writes = 0;
    tx_poll_idx = -1;
    tx_delta = -1;
    poll_rx_cyc = -100;
    exp_q.push_back('{1'b1, 5'h08, TB_BAUD});
    exp_q.push_back('{1'b1, 5'h0C, TB_CTRL2});
    PRESETN = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    for (int i = 0; i < 40 && !bus.tx_ready; i++) tick();
    bus.tx_data = b;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'hEE;
    chk("tx_accept", 32'(bus.tx_ready), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    bus.err_clr = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 5'h00, 8'h00,     1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 5'h08, TB_BAUD,  1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 5'h08, TB_BAUD,  1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 5'h0C, TB_CTRL2, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 5'h0C, TB_CTRL2, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 5'h10, 8'h00,     1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 5'h10, 8'h00,     1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 5'h10, 8'h00,     1'b1, 1'b1};

    // Reset release and init sequence, cycle by cycle.
    status_val = 8'h00;
    do_reset();
    chk("rst_rx_err", 32'({bus.rx_valid, bus.rx_data, bus.err_flags}), 32'(0));
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      chk($sformatf("init_c%0d", i),
          32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.init_done, bus.tx_ready}),
          32'(vecs[i]));
    end
    repeat (6) tick();
    chk("sb_init", 32'(exp_q.size()), 32'(0));

    // Byte pushed during init goes out right after the first poll.
    status_val = 8'h01;
    do_reset();
    exp_q.push_back('{1'b1, 5'h00, 8'h55});
    send_tx(8'h55);
    for (int i = 0; i < 40 && !bus.tx_ready; i++) tick();
    chk("tx_ready_back", 32'(bus.tx_ready), 32'(1));
    repeat (10) tick();
    chk("sb_tx", 32'(exp_q.size()), 32'(0));
    chk("tx_writes", 32'(tx_writes), 32'(1));
    chk("tx_poll_idx", 32'(tx_poll_idx), 32'(1));
    chk("tx_delta", 32'(tx_delta), 32'(2));

    // RX has priority over a pending TX.
    status_val = 8'h00;
    send_tx(8'h3C);
    repeat (6) tick();
    chk("tx_held", 32'(bus.tx_ready), 32'(0));
    rxdata_val = 8'hA7;
    exp_q.push_back('{1'b0, 5'h04, 8'hA7});
    exp_q.push_back('{1'b1, 5'h00, 8'h3C});
    status_val = 8'h03;
    for (int i = 0; i < 40 && !bus.rx_valid; i++) tick();
    lat = cyc - poll_rx_cyc;
    chk("rx_valid", 32'(bus.rx_valid), 32'(1));
    chk("rx_data", 32'(bus.rx_data), 32'(8'hA7));
    chk("rx_latency", 32'(lat), 32'(3));
    for (int i = 0; i < 40 && !bus.tx_ready; i++) tick();
    chk("tx_after_rx", 32'(bus.tx_ready), 32'(1));
    chk("sb_rx_tx", 32'(exp_q.size()), 32'(0));

    // Full rx holding register blocks further RXDATA reads.
    rxdata_val = 8'h5A;
    status_val = 8'h02;
    repeat (20) tick();
    chk("rx_blocked", 32'({bus.rx_valid, bus.rx_data}), 32'({1'b1, 8'hA7}));
    exp_q.push_back('{1'b0, 5'h04, 8'h5A});
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    chk("rx_taken", 32'(bus.rx_valid), 32'(0));
    for (int i = 0; i < 40 && !bus.rx_valid; i++) tick();
    chk("rx_data2", 32'({bus.rx_valid, bus.rx_data}), 32'({1'b1, 8'h5A}));
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    repeat (4) tick();
    chk("sb_rx2", 32'(exp_q.size()), 32'(0));

    // Sticky error flags.
    status_val = 8'h14;
    repeat (8) tick();
    chk("err_status", 32'(bus.err_flags), 32'(4'b0101));
    slverr_tx = 1'b1;
    stall_left = 3;
    status_val = 8'h15;
    exp_q.push_back('{1'b1, 5'h00, 8'h99});
    send_tx(8'h99);
    for (int i = 0; i < 60 && !bus.tx_ready; i++) tick();
    repeat (2) tick();
    chk("err_slverr", 32'(bus.err_flags), 32'(4'b1101));
    chk("sb_err_tx", 32'(exp_q.size()), 32'(0));
    slverr_tx = 1'b0;
    status_val = 8'h08;
    repeat (6) tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      found = bus.PSEL && bus.PENABLE && bus.PREADY && (bus.PADDR == 5'h10);
      if (!found) tick();
    end
    chk("poll_found", 32'(found), 32'(1));
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err_clr_set_wins", 32'(bus.err_flags), 32'(4'b0010));
    status_val = 8'h01;
    repeat (4) tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err_clr", 32'(bus.err_flags), 32'(4'b0000));

    // Stalled TXW, then reset in the middle of the access.
    stall_left = 1000;
    send_tx(8'h77);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      found = bus.PSEL && bus.PENABLE && bus.PWRITE && (bus.PADDR == 5'h00);
      if (!found) tick();
    end
    chk("txw_found", 32'(found), 32'(1));
    repeat (5) tick();
    chk("stall_hold", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.tx_ready}),
        32'({1'b1, 1'b1, 1'b1, 5'h00, 8'h77, 1'b0}));
    PRESETN = 1'b0;
    #1;
    chk("async_drop", 32'({bus.PSEL, bus.PENABLE}), 32'(0));
    do_reset();
    chk("rst_again", 32'({bus.PSEL, bus.tx_ready, bus.init_done}), 32'({1'b0, 1'b1, 1'b0}));
    tick();
    chk("cfg1_restart", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}),
        32'({1'b1, 1'b0, 1'b1, 5'h08, TB_BAUD}));
    repeat (8) tick();
    chk("sb_restart", 32'(exp_q.size()), 32'(0));
    chk("init_again", 32'(bus.init_done), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
